div_issue_ctrl: RTL and testbench

- Front-end controller for the iterative integer divider.
- Accepts divide/remainder uops from the issue stage into a small in-order queue and launches them one at a time into the divider.
- Resolves RISC-V divide-by-zero and signed-overflow cases locally through a bypass register, without using the divider.
- Arbitrates the single writeback slot between the bypass register and divider completions, and squashes in-flight work on flush.

---
 rtl/div_issue_ctrl.sv | 174 +++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// Issue front-end for the iterative divider: in-order uop queue, local resolution
// of divide-by-zero / signed overflow, and writeback arbitration with flush squash.
module div_issue_ctrl #(
  parameter int DEPTH          = 4,
  parameter int LG_DEPTH       = 2,
  parameter int M_WIDTH        = 64,
  parameter int LG_ROB_ENTRIES = 6,
  parameter int LG_PRF_ENTRIES = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      wb_slot_used,
  input  logic                      uop_valid,
  output logic                      uop_ready,
  input  logic [M_WIDTH-1:0]        uop_srcA,
  input  logic [M_WIDTH-1:0]        uop_srcB,
  input  logic [LG_ROB_ENTRIES-1:0] uop_rob_ptr,
  input  logic [LG_PRF_ENTRIES-1:0] uop_prf_ptr,
  input  logic                      uop_signed,
  input  logic                      uop_rem,
  input  logic                      uop_w,
  output logic                      div_start,
  output logic [M_WIDTH-1:0]        div_inA,
  output logic [M_WIDTH-1:0]        div_inB,
  output logic [LG_ROB_ENTRIES-1:0] div_rob_ptr,
  output logic [LG_PRF_ENTRIES-1:0] div_prf_ptr,
  output logic                      div_signed,
  output logic                      div_rem,
  output logic                      div_w,
  output logic                      div_wb_slot_used,
  input  logic                      div_complete,
  input  logic [M_WIDTH-1:0]        div_y,
  input  logic [LG_ROB_ENTRIES-1:0] div_rob_ptr_out,
  input  logic [LG_PRF_ENTRIES-1:0] div_prf_ptr_out,
  output logic                      wb_valid,
  output logic [M_WIDTH-1:0]        wb_data,
  output logic [LG_ROB_ENTRIES-1:0] wb_rob_ptr,
  output logic [LG_PRF_ENTRIES-1:0] wb_prf_ptr,
  output logic                      busy
);

  localparam logic [LG_DEPTH:0]  PTR_ONE = 1;
  localparam logic [M_WIDTH-1:0] MIN_NEG = {1'b1, {(M_WIDTH-1){1'b0}}};

  logic [M_WIDTH-1:0]        q_srcA [DEPTH];
  logic [M_WIDTH-1:0]        q_srcB [DEPTH];
  logic [LG_ROB_ENTRIES-1:0] q_rob  [DEPTH];
  logic [LG_PRF_ENTRIES-1:0] q_prf  [DEPTH];
  logic                      q_signed [DEPTH];
  logic                      q_rem    [DEPTH];
  logic                      q_w      [DEPTH];

  logic [LG_DEPTH:0]   wptr, rptr;
  logic [LG_DEPTH-1:0] widx, ridx;
  logic                full, empty, enq, pop;

  logic                      inflight, squash;
  logic                      bypass_valid;
  logic [M_WIDTH-1:0]        byp_data;
  logic [LG_ROB_ENTRIES-1:0] byp_rob;
  logic [LG_PRF_ENTRIES-1:0] byp_prf;

  logic [M_WIDTH-1:0]        h_srcA, h_srcB, a_ext, byp_next;
  logic [LG_ROB_ENTRIES-1:0] h_rob;
  logic [LG_PRF_ENTRIES-1:0] h_prf;
  logic                      h_signed, h_rem, h_w, h_zero, h_ovf, h_special;
  logic                      launch_div, launch_byp, byp_drain, div_wb;

  assign widx  = wptr[LG_DEPTH-1:0];
  assign ridx  = rptr[LG_DEPTH-1:0];
  assign empty = (wptr == rptr);
  assign full  = (wptr[LG_DEPTH] != rptr[LG_DEPTH]) && (widx == ridx);
  assign uop_ready = !full;
  assign enq = uop_valid && !full && !flush;

  assign h_srcA   = q_srcA[ridx];
  assign h_srcB   = q_srcB[ridx];
  assign h_rob    = q_rob[ridx];
  assign h_prf    = q_prf[ridx];
  assign h_signed = q_signed[ridx];
  assign h_rem    = q_rem[ridx];
  assign h_w      = q_w[ridx];

  assign h_zero = h_w ? (h_srcB[31:0] == 32'h0) : (h_srcB == '0);
  assign h_ovf  = h_signed && (h_w ? (h_srcA[31:0] == 32'h8000_0000 && h_srcB[31:0] == 32'hFFFF_FFFF)
                                   : (h_srcA == MIN_NEG && h_srcB == '1));
  assign h_special = h_zero || h_ovf;

  // Zero-divisor cases win over overflow; W results sign-extend from bit 31.
  always_comb begin
    a_ext = h_w ? {{(M_WIDTH-32){h_srcA[31]}}, h_srcA[31:0]} : h_srcA;
    if (h_zero) byp_next = h_rem ? a_ext : '1;
    else        byp_next = h_rem ? '0 : a_ext;
  end

  assign launch_div = !empty && !h_special && !inflight && !flush;
  assign launch_byp = !empty && h_special && !bypass_valid && !flush;
  assign pop        = launch_div || launch_byp;

  assign div_start   = launch_div;
  assign div_inA     = empty ? '0 : h_srcA;
  assign div_inB     = empty ? '0 : h_srcB;
  assign div_rob_ptr = empty ? '0 : h_rob;
  assign div_prf_ptr = empty ? '0 : h_prf;
  assign div_signed  = !empty && h_signed;
  assign div_rem     = !empty && h_rem;
  assign div_w       = !empty && h_w;

  // Holding the divider off while the bypass is pending keeps the two sources exclusive.
  assign div_wb_slot_used = wb_slot_used || bypass_valid;
  assign byp_drain = bypass_valid && !wb_slot_used && !div_complete && !flush;
  assign div_wb    = div_complete && !squash && !flush;

  assign wb_valid   = byp_drain || div_wb;
  assign wb_data    = byp_drain ? byp_data : (div_wb ? div_y : '0);
  assign wb_rob_ptr = byp_drain ? byp_rob  : (div_wb ? div_rob_ptr_out : '0);
  assign wb_prf_ptr = byp_drain ? byp_prf  : (div_wb ? div_prf_ptr_out : '0);
  assign busy = !empty || inflight || bypass_valid;

  always_ff @(posedge clk) begin
    if (enq) begin
      q_srcA[widx]   <= uop_srcA;
      q_srcB[widx]   <= uop_srcB;
      q_rob[widx]    <= uop_rob_ptr;
      q_prf[widx]    <= uop_prf_ptr;
      q_signed[widx] <= uop_signed;
      q_rem[widx]    <= uop_rem;
      q_w[widx]      <= uop_w;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr         <= '0;
      rptr         <= '0;
      bypass_valid <= 1'b0;
      byp_data     <= '0;
      byp_rob      <= '0;
      byp_prf      <= '0;
    end else if (flush) begin
      wptr         <= '0;
      rptr         <= '0;
      bypass_valid <= 1'b0;
    end else begin
      if (enq) wptr <= wptr + PTR_ONE;
      if (pop) rptr <= rptr + PTR_ONE;
      if (launch_byp) begin
        bypass_valid <= 1'b1;
        byp_data     <= byp_next;
        byp_rob      <= h_rob;
        byp_prf      <= h_prf;
      end else if (byp_drain) begin
        bypass_valid <= 1'b0;
      end
    end
  end

  // A flushed in-flight op stays tracked until the divider finishes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else if (div_complete) begin
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else if (launch_div) begin
      inflight <= 1'b1;
    end else if (flush && inflight) begin
      squash <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a behavioural fixed-latency divider.
module tb_div_issue_ctrl;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, wb_slot_used = 1'b0, uop_valid = 1'b0;
  logic        uop_ready;
  logic [63:0] uop_srcA = '0, uop_srcB = '0;
  logic [5:0]  uop_rob_ptr = '0;
  logic [6:0]  uop_prf_ptr = '0;
  logic        uop_signed = 1'b0, uop_rem = 1'b0, uop_w = 1'b0;
  logic        div_start;
  logic [63:0] div_inA, div_inB;
  logic [5:0]  div_rob_ptr;
  logic [6:0]  div_prf_ptr;
  logic        div_signed, div_rem, div_w, div_wb_slot_used;
  logic        div_complete;
  logic [63:0] div_y;
  logic [5:0]  div_rob_ptr_out;
  logic [6:0]  div_prf_ptr_out;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic [5:0]  wb_rob_ptr;
  logic [6:0]  wb_prf_ptr;
  logic        busy;

  div_issue_ctrl #(.DEPTH(4), .LG_DEPTH(2), .M_WIDTH(64), .LG_ROB_ENTRIES(6), .LG_PRF_ENTRIES(7)) dut (
    .clk(clk), .reset(rst_n), .flush(flush), .wb_slot_used(wb_slot_used),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_srcA(uop_srcA), .uop_srcB(uop_srcB),
    .uop_rob_ptr(uop_rob_ptr), .uop_prf_ptr(uop_prf_ptr), .uop_signed(uop_signed),
    .uop_rem(uop_rem), .uop_w(uop_w), .div_start(div_start), .div_inA(div_inA),
    .div_inB(div_inB), .div_rob_ptr(div_rob_ptr), .div_prf_ptr(div_prf_ptr),
    .div_signed(div_signed), .div_rem(div_rem), .div_w(div_w),
    .div_wb_slot_used(div_wb_slot_used), .div_complete(div_complete), .div_y(div_y),
    .div_rob_ptr_out(div_rob_ptr_out), .div_prf_ptr_out(div_prf_ptr_out),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rob_ptr(wb_rob_ptr),
    .wb_prf_ptr(wb_prf_ptr), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cmp_cnt = 0;
  int mon_idx;

  typedef struct {
    logic [63:0] data;
    logic [5:0]  rob;
    logic [6:0]  prf;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Behavioural divider: fixed latency, holds its result while the slot is busy.
  function automatic logic [63:0] dref(input logic [63:0] a, input logic [63:0] b,
                                       input logic s, input logic r, input logic w);
    logic [31:0] q32;
    logic [63:0] q;
    if (w) begin
      if (s) q32 = r ? $signed(a[31:0]) % $signed(b[31:0]) : $signed(a[31:0]) / $signed(b[31:0]);
      else   q32 = r ? a[31:0] % b[31:0] : a[31:0] / b[31:0];
      q = {{32{q32[31]}}, q32};
    end else if (s) begin
      q = r ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    end else begin
      q = r ? a % b : a / b;
    end
    return q;
  endfunction

  logic dv_busy;
  int   dv_cnt;
  assign div_complete = dv_busy && (dv_cnt == 0) && !div_wb_slot_used;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_busy <= 1'b0;
      dv_cnt <= 0;
      div_y <= '0;
      div_rob_ptr_out <= '0;
      div_prf_ptr_out <= '0;
    end else if (div_start) begin
      dv_busy <= 1'b1;
      dv_cnt <= LAT;
      div_y <= dref(div_inA, div_inB, div_signed, div_rem, div_w);
      div_rob_ptr_out <= div_rob_ptr;
      div_prf_ptr_out <= div_prf_ptr;
    end else if (dv_busy) begin
      if (dv_cnt != 0) dv_cnt <= dv_cnt - 1;
      else if (!div_wb_slot_used) dv_busy <= 1'b0;
    end
  end

  always @(posedge clk) if (rst_n && div_complete) cmp_cnt <= cmp_cnt + 1;

  // Monitor: every writeback must match exactly one outstanding expectation by ROB tag.
  initial forever begin
    @(negedge clk);
    if (rst_n && wb_valid) begin
      mon_idx = -1;
      foreach (sb[i]) if (mon_idx < 0 && sb[i].rob == wb_rob_ptr) mon_idx = i;
      tests++;
      if (mon_idx < 0) begin
        fails++;
        $display("FAIL wb_unexpected: got rob=%0d data=%h, required no writeback", wb_rob_ptr, wb_data);
      end else begin
        if (wb_data !== sb[mon_idx].data || wb_prf_ptr !== sb[mon_idx].prf) begin
          fails++;
          $display("FAIL wb_result rob=%0d: got data=%h prf=%0d, required data=%h prf=%0d",
                   wb_rob_ptr, wb_data, wb_prf_ptr, sb[mon_idx].data, sb[mon_idx].prf);
        end
        sb.delete(mon_idx);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && div_start) chk("launch_while_divider_busy", {63'b0, dv_busy}, 64'd0);
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s, input logic r,
                       input logic w, input int rob, input logic [63:0] expv, input bit track);
    exp_t e;
    if (track) begin
      e.data = expv; e.rob = 6'(rob); e.prf = 7'(rob + 32);
      sb.push_back(e);
    end
    uop_valid = 1'b1; uop_srcA = a; uop_srcB = b; uop_signed = s; uop_rem = r; uop_w = w;
    uop_rob_ptr = 6'(rob); uop_prf_ptr = 7'(rob + 32);
    @(posedge clk); #1;
    uop_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || dv_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle_in_time"}, {63'b0, n < 300}, 64'd1);
    chk({nm, "_all_results_seen"}, 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  int base;
  bit found;

  initial begin
    #12;
    chk("rst_uop_ready", {63'b0, uop_ready}, 64'd1);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_wb_valid", {63'b0, wb_valid}, 64'd0);
    chk("rst_div_start", {63'b0, div_start}, 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_div_inA", div_inA, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // DIVU 100/7 launches the cycle after enqueue.
    issue(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 1, 64'd14, 1'b1);
    @(negedge clk);
    chk("divu_start", {63'b0, div_start}, 64'd1);
    chk("divu_inA", div_inA, 64'd100);
    chk("divu_inB", div_inB, 64'd7);
    chk("divu_rob", {58'b0, div_rob_ptr}, 64'd1);
    @(posedge clk); #1;
    wait_idle("divu");

    // Ordinary signed / W ops through the divider.
    issue(-64'sd20, 64'd3, 1'b1, 1'b0, 1'b0, 2, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
    issue(-64'sd20, 64'd3, 1'b1, 1'b1, 1'b0, 3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    issue(64'hFFFF_FFFF_0000_0064, 64'h0000_0005_0000_000A, 1'b0, 1'b0, 1'b1, 4, 64'd10, 1'b1);
    issue(64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 17, 64'd0, 1'b1);
    wait_idle("normal_ops");

    // REMU by zero resolves through bypass, written two cycles after enqueue.
    issue(64'h1234, 64'd0, 1'b0, 1'b1, 1'b0, 5, 64'h1234, 1'b1);
    @(negedge clk);
    chk("remz_no_start", {63'b0, div_start}, 64'd0);
    @(negedge clk);
    chk("remz_wb_valid", {63'b0, wb_valid}, 64'd1);
    @(posedge clk); #1;
    issue(64'd5, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b1, 6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    issue(64'h8000_0001, 64'd0, 1'b1, 1'b1, 1'b1, 7, 64'hFFFF_FFFF_8000_0001, 1'b1);
    wait_idle("div_zero");

    // Signed overflow cases.
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 8, 64'h8000_0000_0000_0000, 1'b1);
    issue(64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 9, 64'd0, 1'b1);
    issue(64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 15, 64'hFFFF_FFFF_8000_0000, 1'b1);
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 16, 64'd0, 1'b1);
    wait_idle("overflow");

    // Five back-to-back uops: one launches, four fill the queue.
    issue(64'd1000, 64'd10, 1'b0, 1'b0, 1'b0, 20, 64'd100, 1'b1);
    issue(64'd81, 64'd9, 1'b0, 1'b0, 1'b0, 21, 64'd9, 1'b1);
    issue(64'd17, 64'd5, 1'b0, 1'b1, 1'b0, 22, 64'd2, 1'b1);
    issue(64'hFFFF_FFF0, 64'd4, 1'b1, 1'b0, 1'b1, 23, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    issue(64'h1_0000_0007, 64'd4, 1'b0, 1'b1, 1'b1, 24, 64'd3, 1'b1);
    @(negedge clk);
    chk("fill_uop_ready_low", {63'b0, uop_ready}, 64'd0);
    chk("fill_busy", {63'b0, busy}, 64'd1);
    @(posedge clk); #1;
    wait_idle("fill");

    // Flush with one op in flight and two queued; an enqueue in the flush cycle is dropped.
    issue(64'd60, 64'd6, 1'b0, 1'b0, 1'b0, 10, 64'd0, 1'b0);
    issue(64'd61, 64'd6, 1'b0, 1'b0, 1'b0, 11, 64'd0, 1'b0);
    issue(64'd62, 64'd6, 1'b0, 1'b0, 1'b0, 12, 64'd0, 1'b0);
    flush = 1'b1;
    uop_valid = 1'b1; uop_srcA = 64'd9; uop_srcB = 64'd3; uop_signed = 1'b0; uop_rem = 1'b0; uop_w = 1'b0;
    uop_rob_ptr = 6'd13; uop_prf_ptr = 7'd45;
    @(negedge clk);
    chk("flush_no_start", {63'b0, div_start}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; uop_valid = 1'b0;
    base = cmp_cnt;
    @(negedge clk);
    chk("flush_queue_empty_ready", {63'b0, uop_ready}, 64'd1);
    chk("flush_busy_inflight", {63'b0, busy}, 64'd1);
    chk("flush_no_start_after", {63'b0, div_start}, 64'd0);
    @(posedge clk); #1;
    issue(64'd77, 64'd7, 1'b0, 1'b0, 1'b0, 14, 64'd11, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (div_start) found = 1'b1;
    end
    chk("flush_new_launch_seen", {63'b0, found}, 64'd1);
    chk("flush_launch_after_completion", 64'(cmp_cnt - base), 64'd1);
    chk("flush_launch_rob", {58'b0, div_rob_ptr}, 64'd14);
    @(posedge clk); #1;
    wait_idle("flush");

    // Contention: bypass pending and divider done while the slot is taken elsewhere.
    wb_slot_used = 1'b1;
    issue(64'd50, 64'd5, 1'b0, 1'b0, 1'b0, 30, 64'd10, 1'b1);
    issue(64'h77, 64'd0, 1'b0, 1'b1, 1'b0, 31, 64'h77, 1'b1);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("contend_no_wb", {63'b0, wb_valid}, 64'd0);
      chk("contend_div_slot_used", {63'b0, div_wb_slot_used}, 64'd1);
    end
    @(posedge clk); #1;
    wb_slot_used = 1'b0;
    @(negedge clk);
    chk("contend_first_valid", {63'b0, wb_valid}, 64'd1);
    chk("contend_first_is_bypass", {58'b0, wb_rob_ptr}, 64'd31);
    @(negedge clk);
    chk("contend_second_valid", {63'b0, wb_valid}, 64'd1);
    chk("contend_second_is_div", {58'b0, wb_rob_ptr}, 64'd30);
    @(posedge clk); #1;
    wait_idle("contend");

    // Asynchronous reset with divider busy and bypass pending.
    wb_slot_used = 1'b1;
    issue(64'd90, 64'd9, 1'b0, 1'b0, 1'b0, 40, 64'd0, 1'b0);
    issue(64'd3, 64'd0, 1'b0, 1'b0, 1'b0, 41, 64'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_busy", {63'b0, busy}, 64'd0);
    chk("areset_uop_ready", {63'b0, uop_ready}, 64'd1);
    chk("areset_wb_valid", {63'b0, wb_valid}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wb_slot_used = 1'b0;
    repeat (15) @(negedge clk);
    chk("areset_nothing_pending", {63'b0, busy}, 64'd0);
    chk("final_scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
